ps_pcstck_ctrl: RTL and testbench
=================================

Name: ps_pcstck_ctrl

Overview:
- Parametrised program-sequencer PC stack for the next sequencer generation.
- Replaces the fixed 2-entry stack and pointer/sticky logic.
- Supports configurable depth and width, ureg push/pop, CALL push, RTS pop with return-address handoff, simultaneous push+pop (replace-top), and a top-of-stack ureg read/write port.
- Sits between the instruction decode, the fetch-address mux and the ureg bus-connect.

Parameters:
- AW, 16, width of stack entries and addresses.
- DEPTH, 4, number of stack entries (>=2).
- PW, $clog2(DEPTH+1), pointer width; the pointer counts 0..DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- stk_push  in  1  ureg push of stk_wdata
- stk_pop  in  1  ureg pop; data is discarded
- stk_call  in  1  CALL push of stk_call_addr
- stk_ret  in  1  RTS pop; popped entry is handed out as the return address
- stk_call_addr  in  AW  return address pushed on CALL
- stk_wdata  in  AW  ureg write data, used by push and tos write
- stk_tos_wr  in  1  ureg write to the top entry; pointer unchanged
- stk_stcky_clr  in  1  clear the overflow/underflow stickies
- stk_tos  out  AW  current top entry (entry[pntr-1]; entry[0] when empty)
- stk_pntr  out  PW  current pointer
- stk_ret_vld  out  1  one-cycle strobe: stk_ret_addr valid
- stk_ret_addr  out  AW  popped return address
- stk_stcky  out  4  {unf, ovf, full, empty}

Behaviour:
- Reset:
  - pntr=0, all entries=0, stcky=4'b0001.
  - stk_ret_vld=0, stk_ret_addr=0, stk_tos=0.
  - Reset mid-operation aborts any pending ret strobe.
- Request grouping: push_any=stk_push|stk_call; pop_any=stk_pop|stk_ret.
- Push data: stk_call_addr if stk_call, else stk_wdata.
- All state updates on posedge clk. stk_tos, stk_pntr and stk_stcky are decoded from registers, so there is zero combinational path from inputs.
- Push only:
  - If pntr<DEPTH: entry[pntr]<=data, pntr<=pntr+1.
  - If full: no write, pntr holds, ovf<=1.
- Pop only:
  - If pntr>0: pntr<=pntr-1.
  - If empty: pntr holds, no change (underflow handling in Optional Feature).
- Push and pop in the same cycle (replace-top):
  - If not empty: entry[pntr-1]<=data, pntr unchanged.
  - If empty: treated as push only.
  - The ret strobe still fires with the old top value.
- stk_ret:
  - Next cycle stk_ret_vld=1 and stk_ret_addr=popped entry (the old stk_tos), held until the next ret.
  - stk_ret_vld is not asserted when popping from empty.
- stk_tos_wr:
  - Writes entry[pntr-1] (entry[0] when empty).
  - Ignored whenever push_any or pop_any is active in the same cycle.
- empty = (pntr==0); full = (pntr==DEPTH). Both are decoded from the registered pointer.
- ovf/unf are sticky until stk_stcky_clr. A set event takes priority over clear in the same cycle.
- Boundary behaviour:
  - DEPTH consecutive pushes reach full.
  - The DEPTH+1th push sets ovf and leaves entry[DEPTH-1] intact.
  - The pointer never wraps.

Optional Feature:
- Macro: PS_STK_UNDERFLOW_EN.
- Defined:
  - A pop_any while empty sets stcky[3] (unf).
  - stk_ret on empty asserts stk_ret_vld with stk_ret_addr=0, so the sequencer can trap.
- Undefined:
  - stcky[3] is tied 0.
  - Pop on empty is silently ignored and no ret strobe is issued.

Decomposition:
- Shared package ps_pkg:
  - PS_AW default.
  - Sticky bit indices STK_EMPTY=0, STK_FULL=1, STK_OVF=2, STK_UNF=3.
  - Ureg addresses for PCSTK/PCSTKP/STCKY.
- Sub-module ps_stk_mem:
  - DEPTH x AW register array with async clear.
  - One write port and one combinational read port (top index).
- ps_pcstck_ctrl holds the pointer, flags and request arbitration.

Test Plan:
- Reset, then 4 calls with addresses 0x0010,0x0020,0x0030,0x0040 (DEPTH=4) -> pntr=4, stcky=4'b0010, stk_tos=0x0040.
- From full, push 0x0050 -> pntr=4, ovf=1, stk_tos=0x0040; then assert stk_stcky_clr -> stcky=4'b0010.
- From pntr=2 (tos=0x0020), assert stk_ret -> next cycle stk_ret_vld=1, stk_ret_addr=0x0020, pntr=1, stk_tos=0x0010.
- With pntr=1, assert stk_call(0x0077)+stk_ret together -> pntr=1, stk_tos=0x0077, stk_ret_vld=1 with addr 0x0010.
- From empty, assert stk_pop -> pntr=0, empty=1. With the macro: unf=1; stk_ret gives stk_ret_vld=1 and addr 0. Without the macro: stcky=4'b0001 and no strobe.
- stk_tos_wr 0xBEEF at pntr=3 -> entry[2]=0xBEEF. stk_tos_wr together with stk_push of 0x1111 -> tos write ignored, entry[3]=0x1111, pntr=4.

Source files
------------

// File: rtl/ps_pkg.sv
// Shared program-sequencer package: default address width, PC-stack sticky
// bit positions and the ureg addresses of the PC-stack registers.
package ps_pkg;

  localparam int PS_AW = 16;

  // Bit positions inside the 4-bit stack sticky word.
  localparam int STK_EMPTY = 0;
  localparam int STK_FULL  = 1;
  localparam int STK_OVF   = 2;
  localparam int STK_UNF   = 3;

  // Ureg addresses served by the bus-connect for the PC stack.
  localparam logic [7:0] UREG_PCSTK  = 8'h0C;
  localparam logic [7:0] UREG_PCSTKP = 8'h0D;
  localparam logic [7:0] UREG_STCKY  = 8'h0E;

  // Assemble the sticky word from its individual flags.
  function automatic logic [3:0] stk_stcky_pack(input logic unf, input logic ovf,
                                                input logic full, input logic empty);
    logic [3:0] s;
    s            = 4'b0000;
    s[STK_UNF]   = unf;
    s[STK_OVF]   = ovf;
    s[STK_FULL]  = full;
    s[STK_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/ps_stk_mem.sv
// PC-stack storage: DEPTH x AW register array, asynchronously cleared,
// with one synchronous write port and one combinational read port.
module ps_stk_mem
  import ps_pkg::*;
#(
  parameter int AW    = PS_AW,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [PW-1:0] widx,
  input  logic [AW-1:0] wdata,
  input  logic [PW-1:0] ridx,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem [DEPTH];

  // Entry storage; cleared on reset, one entry written per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (widx == PW'(i)) mem[i] <= wdata;
      end
    end
  end

  // Read mux for the top-of-stack index; out-of-range indices read zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ridx == PW'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/ps_pcstck_ctrl.sv
// Program-sequencer PC stack controller: pointer, sticky flags, request
// arbitration (push / pop / replace-top / top write) and the RTS return
// address strobe.
// Build option: define PS_STK_UNDERFLOW_EN to flag pops from an empty stack
// in the unf sticky and to strobe a zero return address on RTS from empty.
module ps_pcstck_ctrl
  import ps_pkg::*;
#(
  parameter int AW    = PS_AW,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stk_push,
  input  logic          stk_pop,
  input  logic          stk_call,
  input  logic          stk_ret,
  input  logic [AW-1:0] stk_call_addr,
  input  logic [AW-1:0] stk_wdata,
  input  logic          stk_tos_wr,
  input  logic          stk_stcky_clr,
  output logic [AW-1:0] stk_tos,
  output logic [PW-1:0] stk_pntr,
  output logic          stk_ret_vld,
  output logic [AW-1:0] stk_ret_addr,
  output logic [3:0]    stk_stcky
);

  logic [PW-1:0] pntr;
  logic          ovf;
  logic          unf;
  logic          ret_vld;
  logic [AW-1:0] ret_addr;

  logic          empty;
  logic          full;
  logic          push_any;
  logic          pop_any;
  logic [AW-1:0] push_data;
  logic [PW-1:0] top_idx;
  logic          do_replace;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic          unf_set;
  logic          tos_we;
  logic          ret_fire;
  logic          ret_empty;
  logic          mem_we;
  logic [PW-1:0] mem_widx;
  logic [AW-1:0] mem_wdata;
  logic [AW-1:0] tos;

  assign empty     = (pntr == '0);
  assign full      = (pntr == PW'(DEPTH));
  assign push_any  = stk_push | stk_call;
  assign pop_any   = stk_pop | stk_ret;
  assign push_data = stk_call ? stk_call_addr : stk_wdata;
  assign top_idx   = empty ? '0 : (pntr - PW'(1));

  // A push together with a pop on an empty stack degenerates to a plain push.
  assign do_replace = push_any & pop_any & ~empty;
  assign do_push    = push_any & ~do_replace & ~full;
  assign do_pop     = pop_any & ~push_any & ~empty;
  assign ovf_set    = push_any & ~pop_any & full;
  assign tos_we     = stk_tos_wr & ~push_any & ~pop_any;
  assign ret_fire   = stk_ret & ~empty;

`ifdef PS_STK_UNDERFLOW_EN
  assign unf_set   = pop_any & ~push_any & empty;
  assign ret_empty = stk_ret & ~push_any & empty;
`else
  assign unf_set   = 1'b0;
  assign ret_empty = 1'b0;
`endif

  assign mem_we    = do_push | do_replace | tos_we;
  assign mem_widx  = do_push ? pntr : top_idx;
  assign mem_wdata = push_data;

  ps_stk_mem #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .widx  (mem_widx),
    .wdata (mem_wdata),
    .ridx  (top_idx),
    .rdata (tos)
  );

  // Stack pointer: counts 0..DEPTH and never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pntr <= '0;
    end else if (do_push) begin
      pntr <= pntr + PW'(1);
    end else if (do_pop) begin
      pntr <= pntr - PW'(1);
    end
  end

  // Overflow sticky; a set in the same cycle wins over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (stk_stcky_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef PS_STK_UNDERFLOW_EN
  // Underflow sticky; a set in the same cycle wins over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unf <= 1'b0;
    end else if (unf_set) begin
      unf <= 1'b1;
    end else if (stk_stcky_clr) begin
      unf <= 1'b0;
    end
  end
`else
  assign unf = 1'b0;
`endif

  // Return-address handoff: one-cycle strobe, address held until next RTS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_vld  <= 1'b0;
      ret_addr <= '0;
    end else begin
      ret_vld <= ret_fire | ret_empty;
      if (ret_fire) begin
        ret_addr <= tos;
      end else if (ret_empty) begin
        ret_addr <= '0;
      end
    end
  end

  assign stk_tos      = tos;
  assign stk_pntr     = pntr;
  assign stk_ret_vld  = ret_vld;
  assign stk_ret_addr = ret_addr;
  assign stk_stcky    = stk_stcky_pack(unf, ovf, full, empty);

endmodule

// File: tb/tb_ps_pcstck_ctrl.sv
// Self-checking bench for ps_pcstck_ctrl (DEPTH=4, AW=16): directed steps
// followed by random traffic, all checked against a stack model.
module tb_ps_pcstck_ctrl;

  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          stk_push, stk_pop, stk_call, stk_ret;
  logic [AW-1:0] stk_call_addr, stk_wdata;
  logic          stk_tos_wr, stk_stcky_clr;
  logic [AW-1:0] stk_tos;
  logic [PW-1:0] stk_pntr;
  logic          stk_ret_vld;
  logic [AW-1:0] stk_ret_addr;
  logic [3:0]    stk_stcky;

  int tests = 0;
  int fails = 0;

  // Reference model: stack contents (including stale slots) and depth.
  logic [AW-1:0] m_ent [DEPTH];
  int            m_cnt;
  logic          m_ovf, m_unf, m_vld;
  logic [AW-1:0] m_ra;

  always #5 clk = ~clk;

  ps_pcstck_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_call      (stk_call),
    .stk_ret       (stk_ret),
    .stk_call_addr (stk_call_addr),
    .stk_wdata     (stk_wdata),
    .stk_tos_wr    (stk_tos_wr),
    .stk_stcky_clr (stk_stcky_clr),
    .stk_tos       (stk_tos),
    .stk_pntr      (stk_pntr),
    .stk_ret_vld   (stk_ret_vld),
    .stk_ret_addr  (stk_ret_addr),
    .stk_stcky     (stk_stcky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
    m_cnt = 0; m_ovf = 0; m_unf = 0; m_vld = 0; m_ra = '0;
  endtask

  // Next state of the model from the requests seen in one cycle.
  task automatic model_step(input logic push, input logic pop, input logic call,
                            input logic ret, input logic [AW-1:0] caddr,
                            input logic [AW-1:0] wdata, input logic toswr,
                            input logic clr);
    logic          pa, pp, oset, uset;
    logic [AW-1:0] d;
    pa = push | call; pp = pop | ret; d = call ? caddr : wdata;
    oset = 0; uset = 0; m_vld = 0;
    if (pa && pp && m_cnt > 0) begin
      if (ret) begin m_vld = 1; m_ra = m_ent[m_cnt-1]; end
      m_ent[m_cnt-1] = d;
    end else if (pa) begin
      if (m_cnt < DEPTH) begin m_ent[m_cnt] = d; m_cnt++; end
      else oset = 1;
    end else if (pp) begin
      if (m_cnt > 0) begin
        if (ret) begin m_vld = 1; m_ra = m_ent[m_cnt-1]; end
        m_cnt--;
      end else begin
`ifdef PS_STK_UNDERFLOW_EN
        uset = 1;
        if (ret) begin m_vld = 1; m_ra = '0; end
`endif
      end
    end else if (toswr) begin
      m_ent[(m_cnt > 0) ? m_cnt-1 : 0] = wdata;
    end
    m_ovf = oset ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = uset ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] etos;
    logic [3:0]    est;
    etos = (m_cnt > 0) ? m_ent[m_cnt-1] : m_ent[0];
    est  = {m_unf, m_ovf, (m_cnt == DEPTH), (m_cnt == 0)};
    chk({tag, ".pntr"},     32'(stk_pntr),     32'(m_cnt));
    chk({tag, ".tos"},      32'(stk_tos),      32'(etos));
    chk({tag, ".stcky"},    32'(stk_stcky),    32'(est));
    chk({tag, ".ret_vld"},  32'(stk_ret_vld),  32'(m_vld));
    chk({tag, ".ret_addr"}, 32'(stk_ret_addr), 32'(m_ra));
  endtask

  // Apply one cycle of requests, advance the model, then check outputs.
  task automatic step(input string tag, input logic push, input logic pop,
                      input logic call, input logic ret, input logic [AW-1:0] caddr,
                      input logic [AW-1:0] wdata, input logic toswr, input logic clr);
    stk_push = push; stk_pop = pop; stk_call = call; stk_ret = ret;
    stk_call_addr = caddr; stk_wdata = wdata; stk_tos_wr = toswr; stk_stcky_clr = clr;
    model_step(push, pop, call, ret, caddr, wdata, toswr, clr);
    @(posedge clk);
    #1;
    stk_push = 0; stk_pop = 0; stk_call = 0; stk_ret = 0;
    stk_tos_wr = 0; stk_stcky_clr = 0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0;
    stk_push = 0; stk_pop = 0; stk_call = 0; stk_ret = 0;
    stk_call_addr = '0; stk_wdata = '0; stk_tos_wr = 0; stk_stcky_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.stcky_const", 32'(stk_stcky), 32'h1);
    rst = 1'b1;

    // Four calls fill the stack.
    step("call1", 0, 0, 1, 0, 16'h0010, 16'h0, 0, 0);
    step("call2", 0, 0, 1, 0, 16'h0020, 16'h0, 0, 0);
    step("call3", 0, 0, 1, 0, 16'h0030, 16'h0, 0, 0);
    step("call4", 0, 0, 1, 0, 16'h0040, 16'h0, 0, 0);
    chk("full.pntr_const",  32'(stk_pntr),  32'd4);
    chk("full.stcky_const", 32'(stk_stcky), 32'b0010);
    chk("full.tos_const",   32'(stk_tos),   32'h0040);

    // Overflow, then clear.
    step("ovf_push", 1, 0, 0, 0, 16'h0, 16'h0050, 0, 0);
    chk("ovf.stcky_const", 32'(stk_stcky), 32'b0110);
    chk("ovf.tos_const",   32'(stk_tos),   32'h0040);
    step("ovf_clr", 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
    chk("clr.stcky_const", 32'(stk_stcky), 32'b0010);

    // Returns down to one entry.
    step("ret4", 0, 0, 0, 1, 16'h0, 16'h0, 0, 0);
    step("ret3", 0, 0, 0, 1, 16'h0, 16'h0, 0, 0);
    step("ret2", 0, 0, 0, 1, 16'h0, 16'h0, 0, 0);
    chk("ret2.vld_const",  32'(stk_ret_vld),  32'd1);
    chk("ret2.addr_const", 32'(stk_ret_addr), 32'h0020);
    chk("ret2.tos_const",  32'(stk_tos),      32'h0010);
    step("idle_after_ret", 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);

    // Replace-top: call and return together.
    step("call_ret", 0, 0, 1, 1, 16'h0077, 16'h0, 0, 0);
    chk("repl.pntr_const", 32'(stk_pntr),     32'd1);
    chk("repl.tos_const",  32'(stk_tos),      32'h0077);
    chk("repl.addr_const", 32'(stk_ret_addr), 32'h0010);

    // Underflow handling.
    step("pop_last", 0, 1, 0, 0, 16'h0, 16'h0, 0, 0);
    step("pop_empty", 0, 1, 0, 0, 16'h0, 16'h0, 0, 0);
`ifdef PS_STK_UNDERFLOW_EN
    chk("unf.stcky_const", 32'(stk_stcky), 32'b1001);
`else
    chk("unf.stcky_const", 32'(stk_stcky), 32'b0001);
`endif
    step("ret_empty", 0, 0, 0, 1, 16'h0, 16'h0, 0, 0);
    step("unf_clr", 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
    step("push_pop_empty", 1, 1, 0, 0, 16'h0, 16'h5A5A, 0, 0);
    step("pop_back", 0, 1, 0, 0, 16'h0, 16'h0, 0, 0);
    step("toswr_empty", 0, 0, 0, 0, 16'h0, 16'hC0DE, 1, 0);

    // Top-of-stack writes.
    step("tw_call1", 0, 0, 1, 0, 16'h00A1, 16'h0, 0, 0);
    step("tw_call2", 0, 0, 1, 0, 16'h00A2, 16'h0, 0, 0);
    step("tw_call3", 0, 0, 1, 0, 16'h00A3, 16'h0, 0, 0);
    step("toswr", 0, 0, 0, 0, 16'h0, 16'hBEEF, 1, 0);
    chk("toswr.tos_const", 32'(stk_tos), 32'hBEEF);
    step("toswr_push", 1, 0, 0, 0, 16'h0, 16'h1111, 1, 0);
    chk("toswr_push.pntr_const", 32'(stk_pntr), 32'd4);
    chk("toswr_push.tos_const",  32'(stk_tos),  32'h1111);
    step("pop_to_beef", 0, 1, 0, 0, 16'h0, 16'h0, 0, 0);
    chk("beef.tos_const", 32'(stk_tos), 32'hBEEF);

    // Asynchronous reset in the middle of a return strobe.
    step("ret_before_rst", 0, 0, 0, 1, 16'h0, 16'h0, 0, 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step("rand",
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           AW'($urandom), AW'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
